// File: rtl/edge_pulse_gen.sv
// Multi-channel edge detector and pulse stretcher with per-channel synchronisers.
// Define EDGE_PULSE_CNT_EN to build the saturating per-channel event counters.
module edge_pulse_gen #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       data_in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic                      edge_any,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt,
    output logic [CHANNELS-1:0]       evt_sat
);

    localparam int REM_W = $clog2(PULSE_LEN + 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(PULSE_LEN);

    logic [CHANNELS-1:0] det;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   prev;
        logic                   rise;
        logic                   fall;
        logic [REM_W-1:0]       rem;
        logic                   pulse_q;

        // prev tracks the synchronised level every cycle, so mode changes never fake an edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= '0;
                prev <= 1'b0;
            end else begin
                sync[0] <= data_in[i];
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync[k] <= sync[k-1];
                end
                prev <= sync[SYNC_STAGES-1];
            end
        end

        assign rise   = sync[SYNC_STAGES-1] & ~prev;
        assign fall   = ~sync[SYNC_STAGES-1] & prev;
        assign det[i] = (mode[2*i] & rise) | (mode[2*i+1] & fall);

        // A fresh detect reloads the counter, so retriggers extend the pulse without a gap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem     <= '0;
                pulse_q <= 1'b0;
            end else if (det[i]) begin
                rem     <= REM_LOAD;
                pulse_q <= 1'b1;
            end else if (rem > REM_W'(1)) begin
                rem     <= rem - REM_W'(1);
                pulse_q <= 1'b1;
            end else begin
                rem     <= '0;
                pulse_q <= 1'b0;
            end
        end

        assign pulse_out[i] = pulse_q;

`ifdef EDGE_PULSE_CNT_EN
        logic [CNT_W-1:0] cnt;

        // A clear coinciding with a detect keeps that event, hence the load of 1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (cnt_clr[i]) begin
                cnt <= det[i] ? CNT_W'(1) : '0;
            end else if (det[i] && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign evt_cnt[CNT_W*i +: CNT_W] = cnt;
        assign evt_sat[i]                = (cnt == '1);
`endif
    end

`ifndef EDGE_PULSE_CNT_EN
    logic unused_cnt_clr;

    assign evt_cnt        = '0;
    assign evt_sat        = '0;
    assign unused_cnt_clr = |cnt_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_any <= 1'b0;
        end else begin
            edge_any <= |det;
        end
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: a default instance and a stretched, narrow-counter instance.
// Counter expectations follow whether EDGE_PULSE_CNT_EN is defined for the build.
module tb_edge_pulse_gen;

`ifdef EDGE_PULSE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic [3:0]  data_a;
    logic [7:0]  mode_a;
    logic [3:0]  clr_a;
    logic [3:0]  pulse_a;
    logic        any_a;
    logic [31:0] cnt_a;
    logic [3:0]  sat_a;

    logic [1:0]  data_b;
    logic [3:0]  mode_b;
    logic [1:0]  clr_b;
    logic [1:0]  pulse_b;
    logic        any_b;
    logic [5:0]  cnt_b;
    logic [1:0]  sat_b;

    int checks;
    int fails;
    int hi_a [4];

    edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .mode(mode_a), .cnt_clr(clr_a),
        .pulse_out(pulse_a), .edge_any(any_a), .evt_cnt(cnt_a), .evt_sat(sat_a)
    );

    edge_pulse_gen #(.CHANNELS(2), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .mode(mode_b), .cnt_clr(clr_b),
        .pulse_out(pulse_b), .edge_any(any_b), .evt_cnt(cnt_b), .evt_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and sample just after the edge, tallying dut_a pulse-high cycles
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) hi_a[i] += int'(pulse_a[i]);
    endtask

    task automatic applyStimulus(input logic [3:0] da, input logic [1:0] db, input int cycles);
        data_a = da;
        data_b = db;
        for (int c = 0; c < cycles; c++) tick();
    endtask

    task automatic clearTallies();
        for (int i = 0; i < 4; i++) hi_a[i] = 0;
    endtask

    function automatic logic [31:0] expCnt(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    initial begin
        checks = 0;
        fails  = 0;
        clearTallies();
        rst_n  = 1'b0;
        data_a = 4'b0000;
        mode_a = 8'b00_11_10_01;
        clr_a  = 4'b0000;
        data_b = 2'b10;
        mode_b = 4'b01_11;
        clr_b  = 2'b00;

        tick();
        tick();
        checkOutput("rst_pulse_a", pulse_a, 0);
        checkOutput("rst_any_a", any_a, 0);
        checkOutput("rst_cnt_a", cnt_a, 0);
        checkOutput("rst_sat_a", sat_a, 0);
        checkOutput("rst_pulse_b", pulse_b, 0);
        checkOutput("rst_cnt_b", cnt_b, 0);

        // dut_b channel 1 is high across reset release and sees it as a rising edge
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checkOutput($sformatf("rel_pulse_b1_c%0d", c), pulse_b[1], (c >= 3 && c <= 6));
            checkOutput($sformatf("rel_any_b_c%0d", c), any_b, (c == 3));
        end
        checkOutput("rel_cnt_b1", cnt_b[5:3], expCnt(1));
        checkOutput("rel_pulse_a", 32'(hi_a[0] + hi_a[1] + hi_a[2] + hi_a[3]), 0);

        // single-cycle rising pulse on channel 0
        data_a = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checkOutput($sformatf("s1_pulse_a0_c%0d", c), pulse_a[0], (c == 3));
            checkOutput($sformatf("s1_any_a_c%0d", c), any_a, (c == 3));
        end
        checkOutput("s1_cnt_a0", cnt_a[7:0], expCnt(1));
        checkOutput("s1_sat_a", sat_a, 0);
        clearTallies();
        applyStimulus(4'b0000, 2'b10, 6);
        checkOutput("s1_fall_ignored", 32'(hi_a[0]), 0);

        // falling-only on channel 1, both edges on channel 2
        clearTallies();
        applyStimulus(4'b0110, 2'b10, 3);
        checkOutput("s2_rise_pulse", pulse_a[2:1], 2'b10);
        checkOutput("s2_rise_any", any_a, 1);
        applyStimulus(4'b0110, 2'b10, 2);
        applyStimulus(4'b0000, 2'b10, 3);
        checkOutput("s2_fall_pulse", pulse_a[2:1], 2'b11);
        applyStimulus(4'b0000, 2'b10, 3);
        checkOutput("s2_hi_ch1", 32'(hi_a[1]), 1);
        checkOutput("s2_hi_ch2", 32'(hi_a[2]), 2);
        checkOutput("s2_cnt_ch0", cnt_a[7:0], expCnt(1));
        checkOutput("s2_cnt_ch1", cnt_a[15:8], expCnt(1));
        checkOutput("s2_cnt_ch2", cnt_a[23:16], expCnt(2));

        // enabling a mode while the input is already high must not fake an edge
        clearTallies();
        applyStimulus(4'b1000, 2'b10, 5);
        mode_a[7:6] = 2'b01;
        applyStimulus(4'b1000, 2'b10, 5);
        checkOutput("mode_no_spurious", 32'(hi_a[3]), 0);
        checkOutput("mode_no_count", cnt_a[31:24], 0);
        applyStimulus(4'b0000, 2'b10, 4);
        applyStimulus(4'b1000, 2'b10, 5);
        checkOutput("mode_new_edge", 32'(hi_a[3]), 1);
        checkOutput("mode_new_count", cnt_a[31:24], expCnt(1));

        // stretch and retrigger: edges every 2 cycles, last det loads at c=9
        data_b[0] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            checkOutput($sformatf("s3_pulse_c%0d", c), pulse_b[0], (c >= 3 && c <= 12));
            checkOutput($sformatf("s3_any_c%0d", c), any_b, (c >= 3 && c <= 9 && (c % 2) == 1));
            if (c == 2 || c == 4 || c == 6) data_b[0] = ~data_b[0];
        end
        checkOutput("s3_cnt_b0", cnt_b[2:0], expCnt(4));
        checkOutput("s3_sat_b", sat_b, 0);

        // five more edges push the 3-bit count past its maximum
        for (int k = 0; k < 5; k++) begin
            data_b[0] = ~data_b[0];
            tick();
            tick();
        end
        tick();
        tick();
        tick();
        checkOutput("s4_cnt_sat", cnt_b[2:0], expCnt(7));
        checkOutput("s4_sat_flag", sat_b, CNT_EN ? 32'd1 : 32'd0);
        clr_b = 2'b01;
        tick();
        clr_b = 2'b00;
        checkOutput("s4_clr_alone", cnt_b[2:0], 0);
        checkOutput("s4_clr_sat", sat_b, 0);
        data_b[0] = ~data_b[0];
        tick();
        tick();
        clr_b = 2'b01;
        tick();
        clr_b = 2'b00;
        checkOutput("s4_clr_det_cnt", cnt_b[2:0], expCnt(1));
        checkOutput("s4_clr_det_sat", sat_b, 0);
        checkOutput("s4_clr_det_pulse", pulse_b[0], 1);
        tick();
        tick();
        tick();
        tick();
        tick();

        // reset mid-pulse truncates immediately
        data_b[0] = ~data_b[0];
        tick();
        tick();
        tick();
        tick();
        checkOutput("s5_pulse_before", pulse_b[0], 1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_pulse_cut", pulse_b, 0);
        checkOutput("s5_any_cut", any_b, 0);
        checkOutput("s5_cnt_cut", cnt_b, 0);
        checkOutput("s5_cnt_a_cut", cnt_a, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
# edge_pulse_gen

Multi-channel, parametrised edge-to-pulse generator. Each channel synchronises an asynchronous level input, detects rising, falling or both edges under a per-channel mode, and emits a pulse of programmable length. Optional per-channel saturating event counters record the detected edges. The block sits between raw status or strobe inputs and the control logic that needs single-clock-domain event strobes.

## Interface

**Parameters**
- `CHANNELS`, default 4: number of independent channels (≥1).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥1).
- `PULSE_LEN`, default 1: output pulse length in cycles (≥1).
- `CNT_W`, default 8: event counter width. Used only when `EDGE_PULSE_CNT_EN` is defined.

**Ports**
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset, applied to every flop.
- `data_in`, input, CHANNELS: per-channel level inputs; may be asynchronous.
- `mode`, input, 2*CHANNELS: per-channel edge select, channel i at [2i+1:2i]. Encodings: 00 = off, 01 = rising, 10 = falling, 11 = both.
- `cnt_clr`, input, CHANNELS: per-channel synchronous counter clear.
- `pulse_out`, output, CHANNELS: registered per-channel pulse.
- `edge_any`, output, 1: registered OR of all channels' detect strobes.
- `evt_cnt`, output, CHANNELS*CNT_W: per-channel event count, channel i at [CNT_W*(i+1)-1:CNT_W*i].
- `evt_sat`, output, CHANNELS: per-channel counter-saturated flag.

## Operation

**Per-channel pipeline:** sync chain s[1..SYNC_STAGES] → history flop `prev` (holds s[SYNC_STAGES] from the previous cycle) → detect → pulse stretcher.

**Detect (combinational, cycle-local):**
- rise = s[S] & ~prev
- fall = ~s[S] & prev
- det = (mode[0] & rise) | (mode[1] & fall)

**History:** `prev` updates every cycle regardless of mode. Changing `mode` never creates a spurious edge; it only affects edges occurring after the change.

**Stretcher:** down-counter `rem`, width clog2(PULSE_LEN+1).
- det: rem ← PULSE_LEN; `pulse_out` ← 1.
- Otherwise, if rem > 1: rem ← rem−1; `pulse_out` stays 1.
- Otherwise: rem ← 0; `pulse_out` ← 0.
- Retrigger: det while the pulse is active reloads rem and extends the pulse. The output stays high continuously; there is no gap.
- Mode set to off mid-pulse: the active pulse runs to completion.
- PULSE_LEN = 1: `pulse_out` equals det delayed one cycle. This is the legacy single-cycle rising-edge behaviour when mode = 01 and SYNC_STAGES = 1.

**edge_any:** register ← |det across all channels. Always single-cycle; not stretched.

**Counters** (with `EDGE_PULSE_CNT_EN`):
- One count per det, including retriggers.
- Saturate at 2^CNT_W−1. `evt_sat` is high whenever the count equals the maximum.
- `cnt_clr` alone: count ← 0.
- `cnt_clr` and det in the same cycle: count ← 1.

**Reset:** all sync flops, `prev`, `rem`, `pulse_out`, `edge_any`, `evt_cnt` and `evt_sat` ← 0.
- An input held high across reset release is seen as a rising edge, producing one pulse if the channel mode includes rising.
- Asserting `rst_n` mid-pulse truncates the pulse immediately.

## Timing

- **Latency:** a `data_in` transition captured at edge n gives `pulse_out` and `edge_any` high after edge n+SYNC_STAGES. Example: SYNC_STAGES = 2, capture at edge 0, pulse high after edge 2.
- **Pulse width:** exactly PULSE_LEN cycles from the last det.
- **Counter timing:** `evt_cnt` updates on the same edge that `pulse_out` rises.
- **Minimum input width:** input high or low times shorter than one clock may be missed. Edges separated by at least one cycle after synchronisation are each detected.
- **Independence:** channels are fully independent. Simultaneous edges on multiple channels are all detected in the same cycle.

## Configuration

- **`EDGE_PULSE_CNT_EN` defined:** the event counters and saturation flags are built as described in Operation.
- **`EDGE_PULSE_CNT_EN` undefined:**
  - No counter logic is generated.
  - `evt_cnt` and `evt_sat` are tied to 0.
  - `cnt_clr` is ignored.
  - Port list is unchanged.

## Test plan

1. **Rising edge, defaults:** CHANNELS = 4, SYNC_STAGES = 2, PULSE_LEN = 1, mode = 01 on channel 0. Raise `data_in[0]` at edge 10 → `pulse_out[0]` high for exactly cycle 12→13, `edge_any` likewise; `evt_cnt[0]` = 1.
2. **Falling and both modes:** channel 1 mode = 10, channel 2 mode = 11. Toggle both inputs 0→1→0 with 5-cycle spacing → channel 1 gives 1 pulse, channel 2 gives 2 pulses; counts 1 and 2.
3. **Stretch and retrigger:** PULSE_LEN = 4, mode = 11. Edges 2 cycles apart → `pulse_out` continuous high until 4 cycles after the last det; count = number of edges.
4. **Saturation and clear:** CNT_W = 3; generate 9 edges → `evt_cnt` = 7 and `evt_sat` = 1. Assert `cnt_clr` in the same cycle as a det → count = 1 and `evt_sat` = 0.
5. **Reset behaviour:** hold `data_in` = 1 through reset and release → one rising pulse at SYNC_STAGES cycles after release. Assert `rst_n` mid-pulse (PULSE_LEN = 4) → outputs 0 immediately.
6. **Build variant:** compile without `EDGE_PULSE_CNT_EN` and rerun scenario 1 → identical `pulse_out`; `evt_cnt` = 0 and `evt_sat` = 0 throughout.
